ps2_scan_rx: RTL

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and validates start, parity and stop bits. Each good 8-bit scan code is buffered in a small FIFO. The block sits directly upstream of the scan-code → ASCII / seven-segment lookup built on the `MuxKey` selector templates. That lookup consumes `code` when `code_valid && code_ready`.

---
 rtl/ps2_scan_if.sv | 28 ++
 rtl/ps2_scan_rx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ps2_scan_if.sv
// Scan-code stream between the PS/2 receiver and the downstream key lookup.
// The receiver side owns code/valid/status; the consumer drives ready and the overflow clear.
interface ps2_scan_if;
  logic [7:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       frame_err;
  logic       overflow;
  logic       clr_ovf;

  modport master (
    output code,
    output code_valid,
    output frame_err,
    output overflow,
    input  code_ready,
    input  clr_ovf
  );

  modport slave (
    input  code,
    input  code_valid,
    input  frame_err,
    input  overflow,
    output code_ready,
    output clr_ovf
  );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard frame receiver: synchronises the raw pins, checks start/parity/stop
// and buffers good scan codes in a small FIFO for the downstream key lookup.
module ps2_scan_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  ps2_scan_if.master  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TCNT_ONE  = TW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic {IDLE, RECV} state_t;

  // Odd parity over d0..d7 + parity bit, and stop bit must be 1.
  function automatic logic frame_ok(input logic [8:0] bits, input logic stop);
    return (^bits) & stop;
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2: ps2_clk history for edge detection
  logic clk_p0, clk_p1, clk_p2;
  logic dat_p0, dat_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= ps2_data;
      dat_p1 <= dat_p0;
    end
  end

  logic fe;
  logic bit_s;
  assign fe    = clk_p2 & ~clk_p1;
  assign bit_s = dat_p1;

  // Frame FSM
  state_t          state, state_nx;
  logic [3:0]      bitcnt, bitcnt_nx;
  logic [TW-1:0]   tcnt, tcnt_nx;
  logic [8:0]      sr, sr_nx;
  logic            err_nx;
  logic            push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bitcnt        <= 4'd0;
      tcnt          <= '0;
      sr            <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      state         <= state_nx;
      bitcnt        <= bitcnt_nx;
      tcnt          <= tcnt_nx;
      sr            <= sr_nx;
      bus.frame_err <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    tcnt_nx   = tcnt;
    sr_nx     = sr;
    err_nx    = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        tcnt_nx = '0;
        if (fe && !bit_s) begin
          state_nx  = RECV;
          bitcnt_nx = 4'd1;
        end
      end
      RECV: begin
        if (fe) begin
          tcnt_nx = '0;
          if (bitcnt == 4'd10) begin
            state_nx  = IDLE;
            bitcnt_nx = 4'd0;
            if (frame_ok(sr, bit_s)) push   = 1'b1;
            else                     err_nx = 1'b1;
          end else begin
            // LSB-first: after nine shifts sr holds {parity, d7..d0}
            sr_nx     = {bit_s, sr[8:1]};
            bitcnt_nx = bitcnt + 4'd1;
          end
        end else if (tcnt == TCNT_LAST) begin
          state_nx  = IDLE;
          bitcnt_nx = 4'd0;
          tcnt_nx   = '0;
          err_nx    = 1'b1;
        end else begin
          tcnt_nx = tcnt + TCNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Scan-code FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && bus.code_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= sr[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (drop)             bus.overflow <= 1'b1;
      else if (bus.clr_ovf) bus.overflow <= 1'b0;
    end
  end

  assign bus.code       = mem[rd_ptr[AW-1:0]];
  assign bus.code_valid = !empty;

endmodule
